can_rec_arbiter: RTL and testbench

Round-robin receive scheduler for the 32 CAN bus controllers of the MOPSHUB core. It watches per-bus "message pending" requests and grants the shared receive path to one bus at a time by driving `can_rec_select`. It then sequences the read from the selected CAN controller, the hand-off to the uplink (e-link) path, and the clear of the bus request. It sits between the CAN controller bank and the uplink packer, replacing free-running bus polling.

---
 rtl/mopshub_arb_pkg.sv | 24 ++
 rtl/rr_priority_pick.sv | 42 ++++
 rtl/can_rec_arbiter.sv | 154 +++++++++++++++
 tb/tb_can_rec_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mopshub_arb_pkg.sv
// ============================================================================
// Module  : mopshub_arb_pkg
// Purpose : Shared types and constants for the MOPSHUB CAN receive arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mopshub_arb_pkg;

    localparam int          N_BUS       = 32;
    localparam int          SEL_W       = 5;
    localparam logic [15:0] TIMEOUT_DEF = 16'd4000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_WAIT_READ = 3'd2,
        ST_SEND      = 3'd3,
        ST_CLEAR     = 3'd4
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
// Module  : rr_priority_pick
// Purpose : Combinational round-robin search over a request mask, starting at
//           next_ptr and wrapping through index 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick
    import mopshub_arb_pkg::*;
#(
    parameter int P_N_BUS = N_BUS,
    parameter int P_SEL_W = SEL_W
) (
    input  logic [P_N_BUS-1:0] mask,
    input  logic [P_SEL_W-1:0] next_ptr,
    input  logic [P_SEL_W-1:0] n_buses,
    output logic               found,
    output logic [P_SEL_W-1:0] index
);

    // First set mask bit at or after the start point, in circular order
    always_comb begin
        logic [P_SEL_W-1:0] start;
        logic [P_SEL_W-1:0] idx;
        // A stale pointer beyond the active range restarts the search at 0
        start = (next_ptr > n_buses) ? '0 : next_ptr;
        idx   = '0;
        found = 1'b0;
        index = '0;
        for (int i = 0; i < P_N_BUS; i++) begin
            idx = start + P_SEL_W'(i);
            if (!found && mask[idx]) begin
                found = 1'b1;
                index = idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/can_rec_arbiter.sv
// ============================================================================
// Module  : can_rec_arbiter
// Purpose : Round-robin receive scheduler for the MOPSHUB CAN buses. Grants the
//           shared receive path, sequences read / uplink hand-off / clear and
//           aborts stalled transactions.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module can_rec_arbiter
    import mopshub_arb_pkg::*;
#(
    parameter int          P_N_BUS = N_BUS,
    parameter int          P_SEL_W = SEL_W,
    parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [P_SEL_W-1:0] n_buses,
    input  logic [P_N_BUS-1:0] irq_can_rec,
    input  logic               read_done,
    input  logic               uplink_ack,
    output logic [P_SEL_W-1:0] can_rec_select,
    output logic               start_read,
    output logic               uplink_req,
    output logic [P_N_BUS-1:0] irq_clear,
    output logic               busy,
    output logic               timeout_err,
    output logic [7:0]         err_cnt
);

    arb_state_t         state_q, state_d;
    logic [P_SEL_W-1:0] sel_q, sel_d;
    logic [P_SEL_W-1:0] ptr_q, ptr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [7:0]         err_q, err_d;

    logic [P_N_BUS-1:0] w_mask;
    logic               w_found;
    logic [P_SEL_W-1:0] w_pick;
    logic               w_expire;
    logic               w_abort;

    // Requests above the highest active bus index never take part
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < P_N_BUS; i++) begin
            w_mask[i] = irq_can_rec[i] && (P_SEL_W'(i) <= n_buses);
        end
    end

    rr_priority_pick #(
        .P_N_BUS (P_N_BUS),
        .P_SEL_W (P_SEL_W)
    ) u_pick (
        .mask     (w_mask),
        .next_ptr (ptr_q),
        .n_buses  (n_buses),
        .found    (w_found),
        .index    (w_pick)
    );

    // Done / ack take priority over an expiry landing in the same cycle
    assign w_expire = (cnt_q == (TIMEOUT - 16'd1));
    assign w_abort  = w_expire &&
                      (((state_q == ST_WAIT_READ) && !read_done) ||
                       ((state_q == ST_SEND) && !uplink_ack));

    // State register and datapath flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state, timeout counter, round-robin pointer and error counter
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && w_found) begin
                    sel_d   = w_pick;
                    // The pointer only matters back in IDLE, so it can advance at grant
                    ptr_d   = (w_pick == n_buses) ? '0 : w_pick + 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                cnt_d   = '0;
                state_d = ST_WAIT_READ;
            end
            ST_WAIT_READ: begin
                if (read_done) begin
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end else if (w_expire) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SEND: begin
                if (uplink_ack) begin
                    state_d = ST_CLEAR;
                end else if (w_expire) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (w_abort && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // Outputs decode from state so reset clears them without waiting for a clock
    always_comb begin
        can_rec_select = sel_q;
        start_read     = (state_q == ST_READ);
        uplink_req     = (state_q == ST_SEND);
        busy           = (state_q != ST_IDLE);
        timeout_err    = w_abort;
        err_cnt        = err_q;
        irq_clear      = '0;
        if (state_q == ST_CLEAR) begin
            irq_clear = {{(P_N_BUS-1){1'b0}}, 1'b1} << sel_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_can_rec_arbiter.sv
// ============================================================================
// Module  : tb_can_rec_arbiter
// Purpose : Self-checking bench for can_rec_arbiter: grant-order vector table
//           plus directed timeout, race, saturation and reset sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_can_rec_arbiter;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [4:0]  n_buses;
    logic [31:0] irq_can_rec;
    logic        read_done;
    logic        uplink_ack;
    logic [4:0]  can_rec_select;
    logic        start_read;
    logic        uplink_req;
    logic [31:0] irq_clear;
    logic        busy;
    logic        timeout_err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    can_rec_arbiter #(
        .P_N_BUS (32),
        .P_SEL_W (5),
        .TIMEOUT (16'd16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .n_buses        (n_buses),
        .irq_can_rec    (irq_can_rec),
        .read_done      (read_done),
        .uplink_ack     (uplink_ack),
        .can_rec_select (can_rec_select),
        .start_read     (start_read),
        .uplink_req     (uplink_req),
        .irq_clear      (irq_clear),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .err_cnt        (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        en;
        logic [4:0]  nb;
        logic [31:0] irq;
        logic [4:0]  sel;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Wait (bounded) for the READ cycle of the next grant
    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!ok) begin
                @(negedge clk);
                if (start_read) ok = 1'b1;
            end
        end
    endtask

    // One full transaction with prompt read_done and uplink_ack
    task automatic run_txn(input string nm, input logic [4:0] exp_sel);
        bit ok;
        wait_grant(ok);
        chk({nm, " grant"}, 32'(ok), 32'd1);
        if (ok) begin
            chk({nm, " select"}, 32'(can_rec_select), 32'(exp_sel));
            @(negedge clk);
            chk({nm, " start_read single"}, 32'(start_read), 32'd0);
            read_done = 1'b1;
            @(negedge clk);
            read_done = 1'b0;
            chk({nm, " uplink_req"}, 32'(uplink_req), 32'd1);
            uplink_ack = 1'b1;
            @(negedge clk);
            uplink_ack = 1'b0;
            chk({nm, " irq_clear"}, irq_clear, 32'd1 << exp_sel);
            chk({nm, " uplink_req drop"}, 32'(uplink_req), 32'd0);
            @(negedge clk);
            chk({nm, " idle"}, {31'd0, busy} | irq_clear, 32'd0);
        end
    endtask

    initial begin
        bit          ok;
        int          first;
        int          pulses;
        bit          seen;

        vt[0]  = '{1'b1, 5'd31, 32'h0000_0080, 5'd7};
        vt[1]  = '{1'b1, 5'd31, 32'h0010_0008, 5'd20};
        vt[2]  = '{1'b1, 5'd31, 32'h0010_0008, 5'd3};
        vt[3]  = '{1'b1, 5'd31, 32'h0010_0008, 5'd20};
        vt[4]  = '{1'b1, 5'd31, 32'h0010_0008, 5'd3};
        vt[5]  = '{1'b1, 5'd5,  32'h4000_0024, 5'd5};
        vt[6]  = '{1'b1, 5'd5,  32'h4000_0024, 5'd2};
        vt[7]  = '{1'b1, 5'd5,  32'h4000_0024, 5'd5};
        vt[8]  = '{1'b1, 5'd5,  32'h4000_0024, 5'd2};
        vt[9]  = '{1'b1, 5'd31, 32'h4000_0024, 5'd5};
        vt[10] = '{1'b1, 5'd1,  32'h0000_0023, 5'd0};
        vt[11] = '{1'b1, 5'd1,  32'h0000_0023, 5'd1};
        vt[12] = '{1'b1, 5'd1,  32'h0000_0023, 5'd0};
        vt[13] = '{1'b0, 5'd1,  32'h0000_0003, 5'd0};
        vt[14] = '{1'b1, 5'd31, 32'h8000_0001, 5'd31};
        vt[15] = '{1'b1, 5'd31, 32'h8000_0001, 5'd0};

        rst         = 1'b1;
        enable      = 1'b0;
        n_buses     = 5'd31;
        irq_can_rec = '0;
        read_done   = 1'b0;
        uplink_ack  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset select", 32'(can_rec_select), 32'd0);
        chk("reset flags", {27'd0, start_read, uplink_req, busy, timeout_err, 1'b0}, 32'd0);
        chk("reset irq_clear", irq_clear, 32'd0);
        chk("reset err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Grant-order table
        for (int v = 0; v < 16; v++) begin
            irq_can_rec = vt[v].irq;
            n_buses     = vt[v].nb;
            enable      = vt[v].en;
            if (vt[v].en) begin
                run_txn($sformatf("vec%0d", v), vt[v].sel);
            end else begin
                seen = 1'b0;
                repeat (8) begin
                    @(negedge clk);
                    if (busy || start_read) seen = 1'b1;
                end
                chk($sformatf("vec%0d disabled no grant", v), 32'(seen), 32'd0);
            end
        end

        // Read timeout: bus 9 never answers
        irq_can_rec = 32'h0000_0200;
        n_buses     = 5'd31;
        wait_grant(ok);
        chk("to grant", 32'(ok), 32'd1);
        chk("to select", 32'(can_rec_select), 32'd9);
        first = 0;
        seen  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (irq_clear != 0) seen = 1'b1;
            if (timeout_err && first == 0) begin
                first       = i;
                irq_can_rec = '0;
            end
        end
        chk("to latency", 32'(first), 32'd16);
        chk("to no irq_clear", 32'(seen), 32'd0);
        chk("to err_cnt", 32'(err_cnt), 32'd1);
        chk("to idle", 32'(busy), 32'd0);
        irq_can_rec = 32'h0000_1200;
        run_txn("after to bus12", 5'd12);
        run_txn("after to bus9", 5'd9);

        // Done / ack arriving exactly in the expiry cycle
        irq_can_rec = 32'h0000_0010;
        wait_grant(ok);
        chk("race grant", 32'(ok), 32'd1);
        repeat (15) @(negedge clk);
        chk("race still waiting", 32'(busy && !uplink_req), 32'd1);
        @(negedge clk);
        read_done = 1'b1;
        #1 chk("race read timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        read_done = 1'b0;
        chk("race in send", 32'(uplink_req), 32'd1);
        repeat (14) @(negedge clk);
        @(negedge clk);
        chk("race send held", 32'(uplink_req), 32'd1);
        uplink_ack = 1'b1;
        #1 chk("race ack timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        uplink_ack  = 1'b0;
        irq_can_rec = '0;
        chk("race irq_clear", irq_clear, 32'h0000_0010);
        chk("race err_cnt", 32'(err_cnt), 32'd1);

        // 300 forced timeouts saturate the error counter
        irq_can_rec = 32'h0000_0010;
        pulses = 0;
        for (int i = 0; i < 7000; i++) begin
            if (pulses < 300) begin
                @(negedge clk);
                if (timeout_err) pulses++;
            end
        end
        irq_can_rec = '0;
        chk("sat pulses", 32'(pulses), 32'd300);
        repeat (2) @(negedge clk);
        chk("sat err_cnt", 32'(err_cnt), 32'd255);

        // Reset while in SEND
        irq_can_rec = 32'h0000_0440;
        wait_grant(ok);
        chk("rst grant", 32'(ok), 32'd1);
        chk("rst select", 32'(can_rec_select), 32'd6);
        @(negedge clk);
        read_done = 1'b1;
        @(negedge clk);
        read_done = 1'b0;
        chk("rst in send", 32'(uplink_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst async flags", {27'd0, start_read, uplink_req, busy, timeout_err, 1'b0}, 32'd0);
        chk("rst async select", 32'(can_rec_select), 32'd0);
        chk("rst async irq_clear", irq_clear, 32'd0);
        chk("rst async err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_txn("post rst lowest", 5'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
